seg7_scan_driver: RTL and testbench
===================================

// Module: seg7_scan_driver
// PURPOSE
//   Parametrised, time-multiplexed N-digit seven-segment driver for board-level readouts.
//   Accepts a binary word and shows it in hex or decimal. Decimal uses a sequential double-dabble converter.
//   Adds leading-zero blanking and overflow indication.
//   Sits between user logic and the board's shared segment bus and digit anodes.
// PARAMETERS
//   DIGITS    4      number of digits scanned (1..8)
//   BIN_W     14     width of value input; must satisfy BIN_W <= 4*DIGITS
//   SCAN_DIV  50000  clk cycles each digit stays enabled (>= 2)
// PORTS
//   clk       in   1        system clock, all logic on rising edge
//   reset     in   1        synchronous, active-high reset
//   value     in   BIN_W    binary number to display
//   load      in   1        pulse: capture value/mode/blank_lz (ignored while busy=1)
//   mode      in   1        0 = hex, 1 = decimal
//   blank_lz  in   1        1 = blank leading zero digits
//   busy      out  1        decimal conversion in progress
//   overflow  out  1        last accepted value not representable in DIGITS digits
//   seg       out  7        active-low segments, seg[6]=a .. seg[0]=g
//   an        out  DIGITS   active-low digit enables, an[0] = least significant digit
// BEHAVIOUR
//   Reset (sync, high): seg=7'b1111111, an=all 1, busy=0, overflow=0, digit index=0, scan counter=0.
//     Display registers=0, disp_valid=0. A reset mid-conversion aborts it; no display update occurs.
//   disp_valid=0 forces an=all 1 and seg=7'b1111111. disp_valid is set on the first display update.
//   Load accept: an edge with load=1 and busy=0 latches value, mode and blank_lz. load with busy=1 is dropped.
//   Hex mode: display registers take value nibbles on the accepting edge. busy stays 0.
//     A zero-extended nibble fills a digit beyond BIN_W. overflow=0 always.
//   Decimal mode: busy=1 from the accepting edge for exactly BIN_W cycles.
//     Each cycle: add 3 to every BCD nibble >= 5, then shift left 1, MSB first.
//     On the edge busy falls, display registers, overflow and disp_valid update together.
//     Displays never show partial BCD.
//   Decimal overflow: value > 10^DIGITS-1 -> overflow=1; every digit shows '-' (7'b1111110).
//   Encoding (active-low): 0=0000001 1=1001111 2=0010010 3=0000110 4=1001100 5=0100100 6=0100000 7=0001111.
//     8=0000000 9=0000100 A=0001000 b=1100000 C=0110001 d=1000010 E=0110000 F=0111000 blank=1111111.
//   Leading-zero blanking, when latched blank_lz=1: each digit above the most significant non-zero digit shows blank.
//     Digit 0 is never blanked, so value 0 shows "0". Blanking is not applied in overflow.
//   Scan: counter runs 0..SCAN_DIV-1. On wrap, digit index advances (DIGITS-1 wraps to 0).
//     seg/an are registered and change one cycle after the index changes. Exactly one an bit is low when disp_valid=1.
//   Scanning runs continuously, including while busy; displayed digits hold old values until the update edge.
// TESTING  (DIGITS=4, BIN_W=14, SCAN_DIV=4)
//   Reset held 3 cycles -> seg=1111111, an=1111, busy=0, overflow=0. Stays blank with no load.
//   Decimal load 1234 -> busy=1 for 14 cycles. Then scan an=1110/1101/1011/0111 with seg=1001100/0000110/0010010/1001111.
//   Decimal load 9999 -> overflow=0, all digits 0000100. Load 10000 -> overflow=1, all digits 1111110.
//   blank_lz=1, decimal 7 -> an0 seg=0001111, digits 1..3 seg=1111111. Decimal 0 -> digit0 0000001, others blank.
//   Hex load 14'h2BEF -> busy stays 0. Digits 0..3 show 0111000/0110000/1100000/0010010.
//   Decimal load 1234, then load 42 during busy, then reset at busy cycle 7 -> 42 ignored, no update, busy=0, display blank.

Source files
------------

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed N-digit seven-segment driver with hex display or decimal display.
// Decimal values go through a sequential double-dabble converter; leading zeros can be blanked and overflow shows dashes.
module seg7_scan_driver #(
    parameter int DIGITS   = 4,
    parameter int BIN_W    = 14,
    parameter int SCAN_DIV = 50000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [BIN_W-1:0]  value,
    input  logic              load,
    input  logic              mode,
    input  logic              blank_lz,
    output logic              busy,
    output logic              overflow,
    output logic [6:0]        seg,
    output logic [DIGITS-1:0] an
);
    localparam int NW  = 4 * DIGITS;
    localparam int SCW = $clog2(SCAN_DIV);
    localparam int IW  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int CW  = $clog2(BIN_W + 1);

    function automatic logic [63:0] max_dec();
        logic [63:0] r;
        r = 64'd1;
        for (int i = 0; i < DIGITS; i++) r = r * 64'd10;
        return r - 64'd1;
    endfunction

    localparam logic [63:0] MAX_DEC = max_dec();

    function automatic logic [6:0] enc(input logic [3:0] n);
        case (n)
            4'h0: enc = 7'b0000001;
            4'h1: enc = 7'b1001111;
            4'h2: enc = 7'b0010010;
            4'h3: enc = 7'b0000110;
            4'h4: enc = 7'b1001100;
            4'h5: enc = 7'b0100100;
            4'h6: enc = 7'b0100000;
            4'h7: enc = 7'b0001111;
            4'h8: enc = 7'b0000000;
            4'h9: enc = 7'b0000100;
            4'hA: enc = 7'b0001000;
            4'hB: enc = 7'b1100000;
            4'hC: enc = 7'b0110001;
            4'hD: enc = 7'b1000010;
            4'hE: enc = 7'b0110000;
            default: enc = 7'b0111000;
        endcase
    endfunction

    typedef enum logic {S_IDLE, S_CONV} state_t;

    state_t           state;
    logic [BIN_W-1:0] shift;
    logic [NW-1:0]    bcd;
    logic [NW-1:0]    bcd_adj;
    logic [NW-1:0]    bcd_next;
    logic [CW-1:0]    step;
    logic             blank_pend;
    logic             ovf_pend;
    logic [NW-1:0]    disp;
    logic             blank_disp;
    logic             disp_valid;

    assign busy = (state == S_CONV);

    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
        end
        bcd_next = NW'({bcd_adj, shift[BIN_W-1]});
    end

    // Pending blank/overflow are applied only together with the finished BCD word.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            shift      <= '0;
            bcd        <= '0;
            step       <= '0;
            blank_pend <= 1'b0;
            ovf_pend   <= 1'b0;
            disp       <= '0;
            overflow   <= 1'b0;
            blank_disp <= 1'b0;
            disp_valid <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (load) begin
                        if (mode) begin
                            state      <= S_CONV;
                            shift      <= value;
                            bcd        <= '0;
                            step       <= '0;
                            blank_pend <= blank_lz;
                            ovf_pend   <= (64'(value) > MAX_DEC);
                        end else begin
                            disp       <= NW'(value);
                            overflow   <= 1'b0;
                            blank_disp <= blank_lz;
                            disp_valid <= 1'b1;
                        end
                    end
                end
                default: begin
                    shift <= shift << 1;
                    bcd   <= bcd_next;
                    step  <= step + 1'b1;
                    if (step == CW'(BIN_W - 1)) begin
                        state      <= S_IDLE;
                        disp       <= bcd_next;
                        overflow   <= ovf_pend;
                        blank_disp <= blank_pend;
                        disp_valid <= 1'b1;
                    end
                end
            endcase
        end
    end

    logic [SCW-1:0] scan_cnt;
    logic [IW-1:0]  idx;
    logic [3:0]     nib;
    logic           nz_above;
    logic [6:0]     cur_seg;

    always_comb begin
        nib      = 4'h0;
        nz_above = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (IW'(i) == idx) nib = disp[4*i +: 4];
            if ((IW'(i) >= idx) && (disp[4*i +: 4] != 4'h0)) nz_above = 1'b1;
        end
        if (overflow)
            cur_seg = 7'b1111110;
        else if (blank_disp && (idx != '0) && !nz_above)
            cur_seg = 7'b1111111;
        else
            cur_seg = enc(nib);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            scan_cnt <= '0;
            idx      <= '0;
            seg      <= 7'b1111111;
            an       <= '1;
        end else begin
            if (scan_cnt == SCW'(SCAN_DIV - 1)) begin
                scan_cnt <= '0;
                idx      <= (idx == IW'(DIGITS - 1)) ? '0 : idx + 1'b1;
            end else begin
                scan_cnt <= scan_cnt + 1'b1;
            end
            seg <= disp_valid ? cur_seg : 7'b1111111;
            an  <= disp_valid ? ~(DIGITS'(1) << idx) : '1;
        end
    end
endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver: expected digit patterns are queued per load and popped as the scan visits each digit.
module tb_seg7_scan_driver;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [13:0] value = '0;
    logic        load = 1'b0;
    logic        mode = 1'b0;
    logic        blank_lz = 1'b0;
    logic        busy;
    logic        overflow;
    logic [6:0]  seg;
    logic [3:0]  an;

    int checks = 0;
    int errors = 0;
    logic [10:0] exp_q[$];

    seg7_scan_driver #(.DIGITS(4), .BIN_W(14), .SCAN_DIV(4)) dut (
        .clk(clk), .reset(reset), .value(value), .load(load), .mode(mode),
        .blank_lz(blank_lz), .busy(busy), .overflow(overflow), .seg(seg), .an(an)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] enc(input int d);
        case (d)
            0: return 7'b0000001;  1: return 7'b1001111;  2: return 7'b0010010;  3: return 7'b0000110;
            4: return 7'b1001100;  5: return 7'b0100100;  6: return 7'b0100000;  7: return 7'b0001111;
            8: return 7'b0000000;  9: return 7'b0000100;  10: return 7'b0001000; 11: return 7'b1100000;
            12: return 7'b0110001; 13: return 7'b1000010; 14: return 7'b0110000; default: return 7'b0111000;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic push_expected(input int val, input bit dec, input bit blz);
        int d[4];
        int msd;
        int div;
        bit ovf;
        logic [6:0] s;
        logic [3:0] a;
        ovf = dec && (val > 9999);
        div = 1;
        msd = 0;
        for (int i = 0; i < 4; i++) begin
            d[i] = dec ? (val / div) % 10 : (val >> (4 * i)) & 15;
            div = div * 10;
            if (d[i] != 0) msd = i;
        end
        for (int i = 0; i < 4; i++) begin
            if (ovf) s = 7'b1111110;
            else if (blz && i > msd) s = 7'b1111111;
            else s = enc(d[i]);
            a = ~(4'b0001 << i);
            exp_q.push_back({a, s});
        end
    endtask

    task automatic do_load(input int val, input bit dec, input bit blz);
        @(posedge clk); #1;
        value = 14'(val); mode = dec; blank_lz = blz; load = 1'b1;
        @(posedge clk); #1;
        load = 1'b0;
    endtask

    task automatic wait_busy(output int n);
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            n++;
            @(posedge clk); #1;
        end
    endtask

    task automatic check_scan(input string tag);
        logic [10:0] e;
        int t;
        repeat (2) @(negedge clk);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            t = 0;
            while (an !== e[10:7] && t < 40) begin
                @(negedge clk);
                t++;
            end
            check(tag, {21'd0, an, seg}, {21'd0, e});
        end
    endtask

    initial begin
        int n;
        repeat (3) @(posedge clk);
        #1;
        check("reset_seg", 32'(seg), 32'h7f);
        check("reset_an", 32'(an), 32'hf);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_ovf", 32'(overflow), 32'd0);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        check("idle_an", 32'(an), 32'hf);
        check("idle_seg", 32'(seg), 32'h7f);

        do_load(1234, 1'b1, 1'b0);
        wait_busy(n);
        check("busy_len_1234", 32'(n), 32'd14);
        push_expected(1234, 1'b1, 1'b0);
        check_scan("dec_1234");
        check("ovf_1234", 32'(overflow), 32'd0);

        do_load(9999, 1'b1, 1'b0);
        wait_busy(n);
        push_expected(9999, 1'b1, 1'b0);
        check_scan("dec_9999");
        check("ovf_9999", 32'(overflow), 32'd0);

        do_load(10000, 1'b1, 1'b0);
        wait_busy(n);
        check("busy_len_10000", 32'(n), 32'd14);
        push_expected(10000, 1'b1, 1'b0);
        check_scan("dec_10000");
        check("ovf_10000", 32'(overflow), 32'd1);

        do_load(7, 1'b1, 1'b1);
        wait_busy(n);
        push_expected(7, 1'b1, 1'b1);
        check_scan("blank_7");
        check("ovf_7", 32'(overflow), 32'd0);

        do_load(0, 1'b1, 1'b1);
        wait_busy(n);
        push_expected(0, 1'b1, 1'b1);
        check_scan("blank_0");

        do_load(14'h2BEF, 1'b0, 1'b0);
        check("hex_busy", 32'(busy), 32'd0);
        push_expected(14'h2BEF, 1'b0, 1'b0);
        check_scan("hex_2bef");
        check("ovf_hex", 32'(overflow), 32'd0);

        // 42 arrives while busy and must be dropped
        do_load(1234, 1'b1, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        value = 14'd42; load = 1'b1;
        @(posedge clk); #1;
        load = 1'b0;
        wait_busy(n);
        check("busy_drop_done", 32'(busy), 32'd0);
        push_expected(1234, 1'b1, 1'b0);
        check_scan("drop_42");

        do_load(1234, 1'b1, 1'b0);
        value = 14'd42; load = 1'b1;
        @(posedge clk); #1;
        load = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("busy_before_abort", 32'(busy), 32'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_ovf", 32'(overflow), 32'd0);
        check("abort_an", 32'(an), 32'hf);
        check("abort_seg", 32'(seg), 32'h7f);
        repeat (30) @(negedge clk);
        check("abort_hold_an", 32'(an), 32'hf);
        check("abort_hold_seg", 32'(seg), 32'h7f);
        check("abort_hold_busy", 32'(busy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
